// File: rtl/translation_pkg.sv
// Shared types for the data-side translation path: memory-stage FSM states,
// exception codes, access sizes and the latched request record.
package translation_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_ISSUE,
    S_WAIT_DATA,
    S_DONE,
    S_DRAIN
  } dmem_state_e;

  localparam logic [4:0] EXC_MOD  = 5'd1;
  localparam logic [4:0] EXC_TLBL = 5'd2;
  localparam logic [4:0] EXC_TLBS = 5'd3;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef struct packed {
    logic [31:0] vaddr;
    logic        is_store;
    logic [1:0]  size;
    logic [31:0] wdata;
  } dmem_req_t;

  function automatic logic dmem_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_HALF: return addr_lo[0];
      SZ_WORD: return addr_lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_strobe_gen.sv
// Byte-enable and lane-replicated store data from access size and address LSBs.
module dmem_strobe_gen (
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  output logic [3:0]  o_strobe,
  output logic [31:0] o_lane_data
);
  import translation_pkg::*;

  always_comb begin
    o_strobe    = 4'b1111;
    o_lane_data = i_wdata;
    case (i_size)
      SZ_BYTE: begin
        o_strobe    = 4'b0001 << i_addr_lo;
        o_lane_data = {4{i_wdata[7:0]}};
      end
      SZ_HALF: begin
        o_strobe    = 4'b0011 << {i_addr_lo[1], 1'b0};
        o_lane_data = {2{i_wdata[15:0]}};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Memory-stage sequencer: TLB lookup, exception decision and one data-bus request per access.
// Optional DMEM_ADDR_ERR_EN: misaligned half/word accesses raise AdEL/AdES before translation.
module dmem_access_ctrl #(
  parameter bit BYPASS_UNMAPPED = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [31:0] req_vaddr,
  input  logic        req_is_store,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_wdata,
  input  logic        flush,
  output logic        stall,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_exc,
  output logic [4:0]  resp_exc_code,
  output logic [31:0] resp_badvaddr,
  output logic [31:0] d_vaddr,
  input  logic [31:0] d_paddr,
  input  logic        d_uncached,
  input  logic        d_mapped,
  input  logic        d_tlb_refill,
  input  logic        d_tlb_invalid,
  input  logic        d_tlb_modified,
  output logic        dbus_valid,
  output logic [31:0] dbus_addr,
  output logic        dbus_uncached,
  output logic [1:0]  dbus_size,
  output logic [3:0]  dbus_strobe,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_addr_ok,
  input  logic        dbus_data_ok,
  input  logic [31:0] dbus_rdata
);
  import translation_pkg::*;

  dmem_state_e r_state, w_next;
  dmem_req_t   r_req;
  logic [31:0] r_paddr;
  logic [31:0] r_rdata;
  logic        r_uncached;
  logic        r_exc;
  logic [4:0]  r_exc_code;
  logic        r_killed;

  logic        w_accept;
  logic        w_stall;
  logic        w_dbus_valid;
  logic        w_resp_valid;
  logic        w_cap_xlate;
  logic        w_cap_rdata;
  logic        w_set_exc;
  logic        w_set_kill;
  logic [4:0]  w_exc_code;
  logic        w_misaligned;
  logic        w_busy;
  logic [3:0]  w_strobe;
  logic [31:0] w_lane;

`ifdef DMEM_ADDR_ERR_EN
  assign w_misaligned = dmem_misaligned(req_size, req_vaddr[1:0]);
`else
  assign w_misaligned = 1'b0;
`endif

  assign w_busy = (r_state != S_IDLE);

  always_comb begin
    w_next       = r_state;
    w_accept     = 1'b0;
    w_stall      = 1'b0;
    w_dbus_valid = 1'b0;
    w_resp_valid = 1'b0;
    w_cap_xlate  = 1'b0;
    w_cap_rdata  = 1'b0;
    w_set_exc    = 1'b0;
    w_set_kill   = 1'b0;
    w_exc_code   = '0;
    case (r_state)
      S_IDLE: begin
        if (req_valid && !flush && !reset) begin
          w_accept = 1'b1;
          w_stall  = 1'b1;
          if (w_misaligned) begin
            w_set_exc  = 1'b1;
            w_exc_code = req_is_store ? EXC_ADES : EXC_ADEL;
            w_next     = S_DONE;
          end else if (BYPASS_UNMAPPED && !d_mapped) begin
            // Unmapped segments translate combinationally, so capture now.
            w_cap_xlate = 1'b1;
            w_next      = S_ISSUE;
          end else begin
            w_next = S_LOOKUP;
          end
        end
      end
      S_LOOKUP: begin
        w_stall = 1'b1;
        if (flush) begin
          w_next = S_IDLE;
        end else begin
          w_cap_xlate = 1'b1;
          if (d_tlb_refill || d_tlb_invalid) begin
            w_set_exc  = 1'b1;
            w_exc_code = r_req.is_store ? EXC_TLBS : EXC_TLBL;
            w_next     = S_DONE;
          end else if (d_tlb_modified && r_req.is_store) begin
            w_set_exc  = 1'b1;
            w_exc_code = EXC_MOD;
            w_next     = S_DONE;
          end else begin
            w_next = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        w_stall      = 1'b1;
        w_dbus_valid = 1'b1;
        w_set_kill   = flush;
        // A killed request still owns the bus until its address phase completes.
        if (dbus_addr_ok) begin
          if (r_killed || flush) begin
            w_next = dbus_data_ok ? S_IDLE : S_DRAIN;
          end else if (dbus_data_ok) begin
            w_cap_rdata = 1'b1;
            w_next      = S_DONE;
          end else begin
            w_next = S_WAIT_DATA;
          end
        end
      end
      S_WAIT_DATA: begin
        w_stall = 1'b1;
        if (flush) begin
          w_next = dbus_data_ok ? S_IDLE : S_DRAIN;
        end else if (dbus_data_ok) begin
          w_cap_rdata = 1'b1;
          w_next      = S_DONE;
        end
      end
      S_DONE: begin
        w_resp_valid = !flush;
        w_next       = S_IDLE;
      end
      S_DRAIN: begin
        w_stall = 1'b1;
        if (dbus_data_ok) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_req      <= '0;
      r_paddr    <= '0;
      r_uncached <= 1'b0;
      r_exc      <= 1'b0;
      r_exc_code <= '0;
      r_rdata    <= '0;
      r_killed   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_req.vaddr    <= req_vaddr;
        r_req.is_store <= req_is_store;
        r_req.size     <= req_size;
        r_req.wdata    <= req_wdata;
        r_exc          <= 1'b0;
        r_exc_code     <= '0;
        r_rdata        <= '0;
        r_killed       <= 1'b0;
      end
      if (w_cap_xlate) begin
        r_paddr    <= d_paddr;
        r_uncached <= d_uncached;
      end
      if (w_set_exc) begin
        r_exc      <= 1'b1;
        r_exc_code <= w_exc_code;
      end
      if (w_cap_rdata) begin
        r_rdata <= dbus_rdata;
      end
      if (w_set_kill) begin
        r_killed <= 1'b1;
      end
    end
  end

  dmem_strobe_gen u_strobe (
    .i_size      (r_req.size),
    .i_addr_lo   (r_req.vaddr[1:0]),
    .i_wdata     (r_req.wdata),
    .o_strobe    (w_strobe),
    .o_lane_data (w_lane)
  );

  assign d_vaddr       = reset ? '0 : (w_busy ? r_req.vaddr : req_vaddr);
  assign stall         = w_stall;
  assign resp_valid    = w_resp_valid;
  assign resp_exc      = w_resp_valid & r_exc;
  assign resp_exc_code = (w_resp_valid && r_exc) ? r_exc_code : '0;
  assign resp_badvaddr = (w_resp_valid && r_exc) ? r_req.vaddr : '0;
  assign resp_rdata    = w_resp_valid ? r_rdata : '0;
  assign dbus_valid    = w_dbus_valid;
  assign dbus_addr     = r_paddr;
  assign dbus_uncached = r_uncached;
  assign dbus_size     = r_req.size;
  assign dbus_strobe   = r_req.is_store ? w_strobe : 4'b0000;
  assign dbus_wdata    = w_lane;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Randomised bench for dmem_access_ctrl against a transaction-level reference model,
// with a stand-in translation unit (kseg0/kseg1 unmapped) and a latency-programmable data bus.
module tb_dmem_access_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [31:0] req_vaddr;
  logic        req_is_store;
  logic [1:0]  req_size;
  logic [31:0] req_wdata;
  logic        flush;
  logic        stall;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_exc;
  logic [4:0]  resp_exc_code;
  logic [31:0] resp_badvaddr;
  logic [31:0] d_vaddr;
  logic [31:0] d_paddr;
  logic        d_uncached;
  logic        d_mapped;
  logic        d_tlb_refill;
  logic        d_tlb_invalid;
  logic        d_tlb_modified;
  logic        dbus_valid;
  logic [31:0] dbus_addr;
  logic        dbus_uncached;
  logic [1:0]  dbus_size;
  logic [3:0]  dbus_strobe;
  logic [31:0] dbus_wdata;
  logic        dbus_addr_ok;
  logic        dbus_data_ok;
  logic [31:0] dbus_rdata;

  int n_total = 0;
  int n_bad   = 0;

  logic [19:0] cfg_pfn;
  logic        cfg_ref, cfg_inv, cfg_mod, cfg_unc;

  always #5 clk = ~clk;

  dmem_access_ctrl #(.BYPASS_UNMAPPED(1'b1)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_vaddr(req_vaddr), .req_is_store(req_is_store),
    .req_size(req_size), .req_wdata(req_wdata), .flush(flush),
    .stall(stall), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_exc(resp_exc), .resp_exc_code(resp_exc_code), .resp_badvaddr(resp_badvaddr),
    .d_vaddr(d_vaddr), .d_paddr(d_paddr), .d_uncached(d_uncached), .d_mapped(d_mapped),
    .d_tlb_refill(d_tlb_refill), .d_tlb_invalid(d_tlb_invalid), .d_tlb_modified(d_tlb_modified),
    .dbus_valid(dbus_valid), .dbus_addr(dbus_addr), .dbus_uncached(dbus_uncached),
    .dbus_size(dbus_size), .dbus_strobe(dbus_strobe), .dbus_wdata(dbus_wdata),
    .dbus_addr_ok(dbus_addr_ok), .dbus_data_ok(dbus_data_ok), .dbus_rdata(dbus_rdata)
  );

  // Translation stand-in: 0x8000_0000..0xBFFF_FFFF unmapped, everything else uses cfg_pfn.
  assign d_mapped   = (d_vaddr[31:30] != 2'b10);
  assign d_paddr    = d_mapped ? {cfg_pfn, d_vaddr[11:0]} : {3'b000, d_vaddr[28:0]};
  assign d_uncached = d_mapped ? cfg_unc : d_vaddr[29];

  always @(posedge clk) begin
    d_tlb_refill   <= cfg_ref;
    d_tlb_invalid  <= cfg_inv;
    d_tlb_modified <= cfg_mod;
  end

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s act=%h exp=%h @%0t", tag, act, exp, $time);
    end
  endtask

  // fmode: 0 none, 1 flush in WAIT_DATA, 2 flush on first ISSUE cycle, 3 flush one cycle after accept.
  task automatic run_txn(input logic [31:0] va, input logic st, input logic [1:0] sz,
                         input logic [31:0] wd, input logic [31:0] rw, input logic [19:0] pfn,
                         input logic ref_f, input logic inv_f, input logic mod_f, input logic unc,
                         input int alat, input int dlat, input int fmode);
    logic        mapped, mis_err, exc_e, bus_e, resp_e, unc_e;
    logic [4:0]  code_e;
    logic [31:0] pa_e, wd_e, rd_e;
    logic [3:0]  sb_e;
    int          issue_e, bus_seen, pend, resp_cnt, dok_cyc, acyc, fcyc, mode, dl;
    bit          addr_done, fin, killed;

    mode   = fmode;
    dl     = dlat;
    mapped = (va[31:30] != 2'b10);
`ifdef DMEM_ADDR_ERR_EN
    mis_err = (sz == 2'd1 && va[0]) || (sz == 2'd2 && va[1:0] != 2'b00);
`else
    mis_err = 1'b0;
`endif
    exc_e  = 1'b1;
    code_e = 5'd0;
    if (mis_err)                        code_e = st ? 5'd5 : 5'd4;
    else if (mapped && (ref_f || inv_f)) code_e = st ? 5'd3 : 5'd2;
    else if (mapped && mod_f && st)      code_e = 5'd1;
    else                                 exc_e  = 1'b0;
    if (exc_e && mode != 3) mode = 0;
    if (mode == 3 && !mapped && !mis_err) mode = 0;
    if (mode == 1 && dl < 2) dl = 2;

    pa_e  = mapped ? {pfn, va[11:0]} : {3'b000, va[28:0]};
    unc_e = mapped ? unc : va[29];
    case (sz)
      2'd0:    begin sb_e = 4'd1 << va[1:0];          wd_e = {4{wd[7:0]}};  end
      2'd1:    begin sb_e = 4'd3 << (va[1] ? 2 : 0);  wd_e = {2{wd[15:0]}}; end
      default: begin sb_e = 4'hF;                     wd_e = wd;            end
    endcase
    if (!st) sb_e = 4'h0;
    rd_e    = st ? 32'h0 : rw;
    issue_e = mapped ? 2 : 1;
    bus_e   = !exc_e && mode != 3;
    resp_e  = (mode == 0);

    @(negedge clk);
    cfg_pfn = pfn; cfg_ref = ref_f; cfg_inv = inv_f; cfg_mod = mod_f; cfg_unc = unc;
    req_valid = 1'b1; req_vaddr = va; req_is_store = st; req_size = sz; req_wdata = wd;
    bus_seen = 0; pend = 0; resp_cnt = 0; dok_cyc = -1; acyc = -1; fcyc = -1;
    addr_done = 1'b0; fin = 1'b0; killed = 1'b0;

    for (int cyc = 0; cyc < 60 && !fin; cyc++) begin
      if (cyc != 0) @(negedge clk);
      dbus_addr_ok = 1'b0; dbus_data_ok = 1'b0; dbus_rdata = 32'h0; flush = 1'b0;
      if (addr_done && pend > 0) begin
        pend--;
        if (pend == 0) begin dbus_data_ok = 1'b1; dbus_rdata = rd_e; dok_cyc = cyc; end
      end
      if (dbus_valid) begin
        bus_seen++;
        if (bus_seen == 1) chk_eq("issue_cycle", cyc, issue_e);
        chk_eq("bus_addr", dbus_addr, pa_e);
        chk_eq("bus_uncached", {31'b0, dbus_uncached}, {31'b0, unc_e});
        chk_eq("bus_strobe", {28'b0, dbus_strobe}, {28'b0, sb_e});
        chk_eq("bus_size", {30'b0, dbus_size}, {30'b0, sz});
        chk_eq("bus_stall", {31'b0, stall}, 32'd1);
        if (st) chk_eq("bus_wdata", dbus_wdata, wd_e);
        if (bus_seen == alat + 1) begin
          dbus_addr_ok = 1'b1; addr_done = 1'b1; acyc = cyc; pend = dl;
          if (dl == 0) begin dbus_data_ok = 1'b1; dbus_rdata = rd_e; dok_cyc = cyc; end
        end
      end
      if (!killed && ((mode == 3 && cyc == 1) || (mode == 2 && dbus_valid && bus_seen == 1) ||
                      (mode == 1 && addr_done && acyc == cyc - 1))) begin
        flush = 1'b1; killed = 1'b1; fcyc = cyc; req_valid = 1'b0;
      end else if (killed && mode == 1) begin
        req_valid = 1'b1; req_vaddr = va ^ 32'h0000_1000;
      end
      #1;
      if (cyc == 0) begin
        chk_eq("accept_stall", {31'b0, stall}, 32'd1);
        chk_eq("accept_vaddr", d_vaddr, va);
      end
      if (killed && mode == 1 && cyc > fcyc) chk_eq("drain_vaddr", d_vaddr, va);
      if (resp_valid) begin
        resp_cnt++;
        chk_eq("resp_cycle", cyc, exc_e ? (mis_err ? 1 : 2) : dok_cyc + 1);
        chk_eq("resp_exc", {31'b0, resp_exc}, {31'b0, exc_e});
        chk_eq("resp_code", {27'b0, resp_exc_code}, {27'b0, code_e});
        chk_eq("resp_badvaddr", resp_badvaddr, exc_e ? va : 32'h0);
        chk_eq("resp_rdata", resp_rdata, exc_e ? 32'h0 : rd_e);
        chk_eq("done_stall", {31'b0, stall}, 32'd0);
        fin = 1'b1;
      end
      if (killed && mode != 3 && dok_cyc == cyc) fin = 1'b1;
      if (mode == 3 && cyc == 2) begin
        chk_eq("flush_idle", {30'b0, stall, dbus_valid}, 32'd0);
        fin = 1'b1;
      end
    end
    if (!fin) chk_eq("timeout", 32'd0, 32'd1);
    chk_eq("resp_count", resp_cnt, resp_e ? 1 : 0);
    chk_eq("bus_cycles", bus_seen, bus_e ? alat + 1 : 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] va, wd, rw;
    logic [1:0]  sz;
    logic        st;
    int          region, fsel;

    reset = 1'b1; req_valid = 1'b1; req_vaddr = 32'hDEAD_BEEF; req_is_store = 1'b1;
    req_size = 2'd2; req_wdata = 32'hFFFF_FFFF; flush = 1'b0;
    dbus_addr_ok = 1'b0; dbus_data_ok = 1'b0; dbus_rdata = 32'h0;
    cfg_pfn = '0; cfg_ref = 1'b0; cfg_inv = 1'b0; cfg_mod = 1'b0; cfg_unc = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk_eq("rst_ctrl", {27'b0, stall, resp_valid, resp_exc, dbus_valid, dbus_uncached}, 32'd0);
    chk_eq("rst_d_vaddr", d_vaddr, 32'd0);
    chk_eq("rst_rdata", resp_rdata, 32'd0);
    chk_eq("rst_code_bad", resp_badvaddr | {27'b0, resp_exc_code}, 32'd0);
    chk_eq("rst_bus_addr", dbus_addr, 32'd0);
    chk_eq("rst_bus_misc", {26'b0, dbus_size, dbus_strobe}, 32'd0);
    chk_eq("rst_bus_wdata", dbus_wdata, 32'd0);
    reset = 1'b0; req_valid = 1'b0;

    // Directed cases
    run_txn(32'h8000_0010, 1'b0, 2'd2, 32'h0, 32'h1234_5678, 20'h0, 0, 0, 0, 0, 0, 0, 0);
    run_txn(32'h0040_0003, 1'b1, 2'd0, 32'h0000_00A5, 32'h0, 20'h12, 0, 0, 0, 0, 1, 1, 0);
    run_txn(32'h0040_0100, 1'b0, 2'd2, 32'h0, 32'hCAFE_F00D, 20'h34, 1, 0, 0, 0, 0, 0, 0);
    run_txn(32'h0040_0300, 1'b1, 2'd1, 32'h0000_BEEF, 32'h0, 20'h34, 0, 1, 1, 0, 0, 0, 0);
    run_txn(32'h0040_0200, 1'b1, 2'd2, 32'h1111_2222, 32'h0, 20'h35, 0, 0, 1, 0, 0, 0, 0);
    run_txn(32'h0040_0200, 1'b0, 2'd2, 32'h0, 32'h5555_AAAA, 20'h35, 0, 0, 1, 1, 2, 1, 0);
    run_txn(32'hA000_0042, 1'b1, 2'd1, 32'h0000_1357, 32'h0, 20'h0, 1, 1, 1, 0, 0, 2, 0);
    run_txn(32'h8000_0040, 1'b0, 2'd2, 32'h0, 32'h7777_7777, 20'h0, 0, 0, 0, 0, 0, 3, 1);
    run_txn(32'h8000_0044, 1'b0, 2'd2, 32'h0, 32'h0BAD_F00D, 20'h0, 0, 0, 0, 0, 0, 1, 0);
    run_txn(32'h0040_0400, 1'b0, 2'd2, 32'h0, 32'h1, 20'h40, 0, 0, 0, 0, 2, 2, 2);
    run_txn(32'h0040_0500, 1'b1, 2'd2, 32'h2, 32'h0, 20'h41, 0, 0, 0, 0, 0, 0, 3);
    run_txn(32'h8000_0002, 1'b1, 2'd2, 32'hABCD_EF01, 32'h0, 20'h0, 0, 0, 0, 0, 0, 0, 0);

    // Reset in the middle of a bus request
    @(negedge clk);
    dbus_addr_ok = 1'b0; dbus_data_ok = 1'b0; flush = 1'b0;
    cfg_ref = 1'b0; cfg_inv = 1'b0; cfg_mod = 1'b0; cfg_pfn = 20'h77;
    req_valid = 1'b1; req_vaddr = 32'h0040_2000; req_is_store = 1'b0; req_size = 2'd2;
    repeat (2) @(negedge clk);
    #1 chk_eq("pre_reset_bus", {31'b0, dbus_valid}, 32'd1);
    reset = 1'b1; req_valid = 1'b0;
    @(negedge clk); #1;
    chk_eq("mid_reset_ctrl", {29'b0, dbus_valid, stall, resp_valid}, 32'd0);
    chk_eq("mid_reset_vaddr", d_vaddr, 32'd0);
    reset = 1'b0;

    for (int n = 0; n < 200; n++) begin
      region = $urandom_range(0, 3);
      va     = $urandom;
      case (region)
        0:       va[31:30] = 2'b00;
        1:       va[31:29] = 3'b100;
        2:       va[31:29] = 3'b101;
        default: va[31:30] = 2'b11;
      endcase
      sz = 2'($urandom_range(0, 2));
      if ($urandom_range(0, 1) == 0) begin
        if (sz == 2'd1) va[0] = 1'b0;
        if (sz == 2'd2) va[1:0] = 2'b00;
      end
      st   = 1'($urandom_range(0, 1));
      wd   = $urandom;
      rw   = $urandom;
      fsel = $urandom_range(0, 9);
      run_txn(va, st, sz, wd, rw, 20'($urandom),
              ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
              ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
              $urandom_range(0, 3), $urandom_range(0, 3),
              (fsel < 7) ? 0 : fsel - 6);
    end

    @(negedge clk);
    req_valid = 1'b0; flush = 1'b0; dbus_addr_ok = 1'b0; dbus_data_ok = 1'b0;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
